// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs a single-outstanding req/gnt/rsp
// fetch to imem, and feeds decode through an output register plus one-entry skid.
// Optional consumed-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_cnt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FULL  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        consume;

  assign consume = out_valid_q && !stall_i;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (consume) begin
      out_valid_d = 1'b0;
      out_inst_d  = NOP_INST;
    end

    if (redirect_i) begin
      // A granted-but-unanswered request must have its response drained.
      fetch_pc_d  = redirect_pc_i & ~32'h3;
      out_valid_d = 1'b0;
      out_inst_d  = NOP_INST;
      skid_inst_d = NOP_INST;
      skid_pc_d   = '0;
      unique case (state_q)
        WAIT:    state_d = imem_rsp_valid_i ? REQ : DRAIN;
        REQ:     state_d = imem_gnt_i ? DRAIN : REQ;
        DRAIN:   state_d = imem_rsp_valid_i ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ:  if (imem_gnt_i) state_d = WAIT;
        WAIT: begin
          if (imem_rsp_valid_i) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (!out_valid_q || consume) begin
              out_valid_d = 1'b1;
              out_inst_d  = imem_rsp_data_i;
              out_pc_d    = fetch_pc_q;
              state_d     = REQ;
            end else begin
              skid_inst_d = imem_rsp_data_i;
              skid_pc_d   = fetch_pc_q;
              state_d     = FULL;
            end
          end
        end
        FULL: begin
          if (consume) begin
            out_valid_d = 1'b1;
            out_inst_d  = skid_inst_q;
            out_pc_d    = skid_pc_q;
            state_d     = REQ;
          end
        end
        DRAIN:   if (imem_rsp_valid_i) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= NOP_INST;
      out_pc_q    <= '0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign imem_req_o   = (state_q == REQ);
  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = out_valid_q;
  assign inst_o       = out_valid_q ? out_inst_q : NOP_INST;
  assign pc_o         = out_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] inst_cnt_q;

  // Squashed instructions are not counted even if decode took them.
  always_ff @(posedge clk) begin
    if (rst)                       inst_cnt_q <= '0;
    else if (consume && !redirect_i) inst_cnt_q <= inst_cnt_q + 32'd1;
  end

  assign inst_cnt_o = inst_cnt_q;
`else
  assign inst_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed sequences with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic        imem_gnt_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] inst_cnt_o;

  fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_o       (imem_req_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .inst_cnt_o       (inst_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: a fetch is either in flight (possibly doomed)
  // or not; decoded-side buffering is a queue of {inst, pc} of depth <= 1.
  bit          m_started;
  bit          m_inflight;
  bit          m_drop;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_opc;
  logic [63:0] m_q[$];
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_req();
    return m_started && !m_inflight && (m_q.size() == 0);
  endfunction

  task automatic model_update();
    bit req, consume;
    if (rst) begin
      m_started = 0; m_inflight = 0; m_drop = 0;
      m_pc = RST_PC; m_valid = 0; m_inst = NOP; m_opc = '0;
      m_q.delete(); m_cnt = '0;
      return;
    end
    req     = model_req();
    consume = m_valid && !stall_i;
    if (consume && !redirect_i) m_cnt = m_cnt + 32'd1;
    if (redirect_i) begin
      m_pc = redirect_pc_i & ~32'h3;
      m_valid = 0;
      m_q.delete();
      if (m_inflight) begin
        if (imem_rsp_valid_i) begin m_inflight = 0; m_drop = 0; end
        else m_drop = 1;
      end else if (req && imem_gnt_i) begin
        m_inflight = 1; m_drop = 1;
      end
    end else begin
      if (consume) begin
        m_valid = 0;
        if (m_q.size() != 0) begin
          {m_inst, m_opc} = m_q.pop_front();
          m_valid = 1;
        end
      end
      if (req && imem_gnt_i) begin
        m_inflight = 1; m_drop = 0;
      end else if (m_inflight && imem_rsp_valid_i) begin
        m_inflight = 0;
        if (m_drop) m_drop = 0;
        else begin
          if (!m_valid) begin m_valid = 1; m_inst = imem_rsp_data_i; m_opc = m_pc; end
          else m_q.push_back({imem_rsp_data_i, m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    m_started = 1;
  endtask

  task automatic compare();
    logic [31:0] exp_cnt;
`ifdef FETCH_PERF_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = '0;
`endif
    check("imem_req", {31'b0, imem_req_o}, {31'b0, model_req()});
    check("imem_addr", imem_addr_o, m_pc);
    check("inst_valid", {31'b0, inst_valid_o}, {31'b0, m_valid});
    check("inst", inst_o, m_valid ? m_inst : NOP);
    if (m_valid) check("pc", pc_o, m_opc);
    check("inst_cnt", inst_cnt_o, exp_cnt);
  endtask

  // Drive one cycle of inputs (from the negedge), clock it, then compare.
  task automatic step(input logic r, input logic g, input logic rv, input logic [31:0] d,
                      input logic st, input logic rd, input logic [31:0] rpc);
    rst = r; imem_gnt_i = g; imem_rsp_valid_i = rv; imem_rsp_data_i = d;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  logic [31:0] exp_cnt3;

  initial begin
    rst = 1; imem_gnt_i = 0; imem_rsp_valid_i = 0; imem_rsp_data_i = '0;
    stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("rst_addr", imem_addr_o, 32'h0000_0100);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_inst", inst_o, 32'h0000_0013);
    check("rst_pc", pc_o, 32'd0);

    // Sequential fetch with immediate grant and one-cycle response.
    step(0, 0, 0, 0, 0, 0, 0);
    check("first_req", {31'b0, imem_req_o}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hD000_0001, 0, 0, 0);
    check("a1_pc", pc_o, 32'h0000_0100);
    check("a1_inst", inst_o, 32'hD000_0001);
    check("a1_addr", imem_addr_o, 32'h0000_0104);

    // Grant withheld: request and address must hold.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check("hold_req", {31'b0, imem_req_o}, 32'd1);
      check("hold_addr", imem_addr_o, 32'h0000_0104);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hD000_0002, 0, 0, 0);
    check("a2_pc", pc_o, 32'h0000_0104);

    // Decode stalls: third instruction lands in the skid.
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 32'hD000_0003, 1, 0, 0);
    check("skid_hold_inst", inst_o, 32'hD000_0002);
    step(0, 1, 0, 0, 1, 0, 0);
    check("full_no_req", {31'b0, imem_req_o}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("skid_out_inst", inst_o, 32'hD000_0003);
    check("skid_out_pc", pc_o, 32'h0000_0108);
    check("after_full_req", {31'b0, imem_req_o}, 32'd1);
    check("after_full_addr", imem_addr_o, 32'h0000_010C);

    // Redirect while waiting: response must be drained.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0000_2002);
    check("drain_addr", imem_addr_o, 32'h0000_2000);
    step(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    check("drain_valid", {31'b0, inst_valid_o}, 32'd0);
    check("drain_req", {31'b0, imem_req_o}, 32'd1);

    // Redirect coincident with response while output is stalled.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hB000_0001, 0, 0, 0);
    check("b1_pc", pc_o, 32'h0000_2000);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 32'hB000_0002, 1, 1, 32'h0000_3000);
    check("sq_valid", {31'b0, inst_valid_o}, 32'd0);
    check("sq_inst", inst_o, 32'h0000_0013);
    check("sq_req", {31'b0, imem_req_o}, 32'd1);
    check("sq_addr", imem_addr_o, 32'h0000_3000);
`ifdef FETCH_PERF_CNT_EN
    exp_cnt3 = 32'd3;
`else
    exp_cnt3 = 32'd0;
`endif
    check("cnt_directed", inst_cnt_o, exp_cnt3);

    // Randomized traffic, including spurious responses and mid-flight resets.
    for (int i = 0; i < 4000; i++) begin
      logic r, g, rv, st, rd;
      r  = ($urandom_range(0, 299) == 0);
      g  = ($urandom_range(0, 9) < 6);
      rv = m_inflight ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 24) == 0);
      step(r, g, rv, $urandom, st, rd, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
